rs_strobe_src: RTL

RS_STROBE_SRC -- requirements
Module: rs_strobe_src

---
 rtl/rs_strobe_src_if.sv | 13 +
 rtl/rs_strobe_src.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rs_strobe_src_if.sv
// rs_strobe_src_if -- request-side handshake into rs_strobe_src.
//   req_valid : upstream offers an Rs value
//   req_data  : 16-bit Rs value offered
//   req_ready : buffer can accept (high whenever the buffer is not full)
// Modports: master (upstream producer), slave (rs_strobe_src).
interface rs_strobe_src_if;
  logic        req_valid;
  logic [15:0] req_data;
  logic        req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/rs_strobe_src.sv
// rs_strobe_src -- buffers Rs values and presents each one to the PC-select
// mux Rs input with a setup cycle, an rs_new strobe of STROBE_CYCLES cycles
// and a one-cycle gap.
//
// Ports:
//   clk      : single clock, all state on the rising edge
//   rst_f    : asynchronous active-low reset
//   req      : rs_strobe_src_if.slave (req_valid, req_data, req_ready)
//   rs_out   : Rs value presented to the consumer
//   rs_new   : registered strobe; consumer captures rs_out on its rising edge
//   busy     : FSM outside IDLE or buffer non-empty
//   dup_drop : one-cycle pulse when a repeated value is suppressed
//
// Parameters: FIFO_DEPTH (power of two, 2..8), STROBE_CYCLES (1..4).
// Optional feature: define RS_DUP_SUPPRESS_EN to suppress strobing a popped
// value equal to the last strobed one; otherwise dup_drop is tied low.
module rs_strobe_src #(
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_f,
  rs_strobe_src_if.slave       req,
  output logic [15:0]          rs_out,
  output logic                 rs_new,
  output logic                 busy,
  output logic                 dup_drop
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [1:0]    LAST_CYC = 2'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  state_t        state;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    cyc_cnt;
  logic          push;
  logic          pop;
  logic          drop_hit;
  logic [15:0]   head;

  assign req.req_ready = (count != FULL_CNT);
  assign push          = req.req_valid && req.req_ready;
  // The head is consumed whenever IDLE sees data, even if it is then dropped.
  assign pop           = (state == IDLE) && (count != '0);
  assign head          = mem[rd_ptr];
  assign busy          = (state != IDLE) || (count != '0);

  // Storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req.req_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state   <= IDLE;
      rs_out  <= '0;
      rs_new  <= 1'b0;
      cyc_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && !drop_hit) begin
            rs_out <= head;
            state  <= SETUP;
          end
        end
        SETUP: begin
          rs_new  <= 1'b1;
          cyc_cnt <= '0;
          state   <= STROBE;
        end
        STROBE: begin
          if (cyc_cnt == LAST_CYC) begin
            rs_new <= 1'b0;
            state  <= GAP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          rs_new <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef RS_DUP_SUPPRESS_EN
  logic [15:0] last_val;
  logic        last_valid;

  assign drop_hit = last_valid && (head == last_val);

  // rs_out is captured as "last strobed" on the SETUP->STROBE edge.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      last_val   <= '0;
      last_valid <= 1'b0;
      dup_drop   <= 1'b0;
    end else begin
      dup_drop <= pop && drop_hit;
      if (state == SETUP) begin
        last_val   <= rs_out;
        last_valid <= 1'b1;
      end
    end
  end
`else
  assign drop_hit = 1'b0;
  assign dup_drop = 1'b0;
`endif

endmodule
